// File: rtl/ram8_scan_pkg.sv
// Shared types and constants for the ram8_scan register bank and scan engine.
package ram8_scan_pkg;

  localparam int unsigned RAM8_DEPTH  = 8;
  localparam int unsigned RAM8_ADDR_W = 3;
  localparam logic [RAM8_ADDR_W-1:0] RAM8_LAST_IDX = 3'd7;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StScan = 1'b1
  } state_e;

endpackage

// File: rtl/ram8_scan_if.sv
// Scan stream bundle: valid/ready handshake carrying the word, its index and a last flag.
interface ram8_scan_if #(
  parameter int unsigned WIDTH = 16
);
  import ram8_scan_pkg::*;

  logic                   s_valid;
  logic                   s_ready;
  logic [WIDTH-1:0]       s_data;
  logic [RAM8_ADDR_W-1:0] s_sel;
  logic                   s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_sel,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_sel,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/ram8_word_mux.sv
// 8-way WIDTH-bit word multiplexer with a 3-bit select.
module ram8_word_mux
  import ram8_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [RAM8_ADDR_W-1:0]           sel_i,
  input  logic [RAM8_DEPTH-1:0][WIDTH-1:0] words_i,
  output logic [WIDTH-1:0]                 word_o
);

  assign word_o = words_i[sel_i];

endmodule

// File: rtl/ram8_scan.sv
// Eight-entry register bank with a random read port and an in-order scan streamer.
// Optional RAM8_SCAN_BYPASS_EN forwards same-edge writes into the captured scan word.
module ram8_scan
  import ram8_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]       in,
  output logic [WIDTH-1:0]       out,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  ram8_scan_if.master            scan
);

  logic [RAM8_DEPTH-1:0][WIDTH-1:0] bank_q;
  state_e                 state_q, state_d;
  logic [RAM8_ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   done_q, done_d;

  logic [RAM8_ADDR_W-1:0] cap_idx;
  logic [WIDTH-1:0]       cap_word;
  logic [WIDTH-1:0]       cap_data;

  // Next word to capture: entry 0 when starting, otherwise the following entry.
  assign cap_idx = (state_q == StIdle) ? '0 : idx_q + 3'd1;

  ram8_word_mux #(
    .WIDTH (WIDTH)
  ) u_out_mux (
    .sel_i   (addr),
    .words_i (bank_q),
    .word_o  (out)
  );

  ram8_word_mux #(
    .WIDTH (WIDTH)
  ) u_cap_mux (
    .sel_i   (cap_idx),
    .words_i (bank_q),
    .word_o  (cap_word)
  );

`ifdef RAM8_SCAN_BYPASS_EN
  assign cap_data = (load && (addr == cap_idx)) ? in : cap_word;
`else
  assign cap_data = cap_word;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          idx_d   = '0;
          data_d  = cap_data;
        end
      end
      StScan: begin
        if (scan.s_ready) begin
          if (idx_q == RAM8_LAST_IDX) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d  = cap_idx;
            data_d = cap_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
    end else if (load) begin
      bank_q[addr] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign scan.s_valid = (state_q == StScan);
  assign scan.s_data  = data_q;
  assign scan.s_sel   = idx_q;
  assign scan.s_last  = (state_q == StScan) && (idx_q == RAM8_LAST_IDX);
  assign busy         = (state_q == StScan);
  assign done         = done_q;

endmodule
